// File: rtl/econet_tx_buffered_if.sv
// Frame request, buffer read port, serial line and status signals of the
// Econet buffered transmitter.
interface econet_tx_buffered_if #(
  parameter int ECO_CNTWIDTH = 9
);
  logic                    start;
  logic [ECO_CNTWIDTH-1:0] start_ptr;
  logic [ECO_CNTWIDTH-1:0] byte_count;
  logic                    abort;
  logic                    buf_rd;
  logic [ECO_CNTWIDTH-1:0] buf_addr;
  logic [7:0]              buf_data;
  logic                    tx_data;
  logic                    tx_en;
  logic                    busy;
  logic                    done;
  logic                    aborted;

  // master: CPU/buffer side; slave: the transmitter
  modport master (
    output start, start_ptr, byte_count, abort, buf_data,
    input  buf_rd, buf_addr, tx_data, tx_en, busy, done, aborted
  );

  modport slave (
    input  start, start_ptr, byte_count, abort, buf_data,
    output buf_rd, buf_addr, tx_data, tx_en, busy, done, aborted
  );
endinterface

// File: rtl/econet_tx_buffered.sv
// Econet/ADLC HDLC transmitter: reads a frame from a circular buffer and sends
// opening flags, bit-stuffed data, bit-stuffed CRC-16/X.25 FCS and a closing flag.
module econet_tx_buffered #(
  parameter int FLAG_COUNT   = 1,
  parameter int ECO_CNTWIDTH = 9,
  parameter int ABORT_ONES   = 8
) (
  input logic                 econet_clk,
  input logic                 valid_rst,
  econet_tx_buffered_if.slave tx_if
);
  localparam int         AW        = ECO_CNTWIDTH;
  localparam int         ACW       = $clog2(ABORT_ONES + 1);
  localparam logic [7:0] FLAG_BYTE = 8'h7E;

  typedef enum logic [2:0] {S_IDLE, S_FLAG, S_DATA, S_FCS, S_CLOSE, S_ABORT} state_t;

  state_t         r_state, w_state;
  logic [3:0]     r_bit_idx, w_bit_idx;
  logic [3:0]     r_flag_cnt, w_flag_cnt;
  logic [2:0]     r_ones, w_ones, w_ones_base;
  logic           r_stuff, w_stuff;
  logic [15:0]    r_shreg, w_shreg;
  logic [15:0]    r_crc, w_crc;
  logic [7:0]     r_next_byte;
  logic [AW-1:0]  r_rd_ptr, w_rd_ptr;
  logic [AW-1:0]  r_fetch_left, w_fetch_left;
  logic [AW-1:0]  r_bytes_left, w_bytes_left;
  logic [ACW-1:0] r_abort_cnt, w_abort_cnt;
  logic           r_tx_data, w_tx_data, r_tx_en, w_tx_en;
  logic           r_busy, r_done, w_done, r_aborted, w_aborted;
  logic           r_buf_rd, w_buf_rd;
  logic [AW-1:0]  r_buf_addr, w_buf_addr;
  logic           w_load, w_crc_en;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    return (crc >> 1) ^ (((crc[0] ^ b) == 1'b1) ? 16'h8408 : 16'h0000);
  endfunction

  // Every register describes the bit currently on the line; this block picks the next one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_state      = r_state;
    w_bit_idx    = r_bit_idx;
    w_flag_cnt   = r_flag_cnt;
    w_stuff      = 1'b0;
    w_shreg      = r_shreg;
    w_crc        = r_crc;
    w_rd_ptr     = r_rd_ptr;
    w_fetch_left = r_fetch_left;
    w_bytes_left = r_bytes_left;
    w_abort_cnt  = r_abort_cnt;
    w_tx_data    = 1'b1;
    w_tx_en      = 1'b1;
    w_done       = 1'b0;
    w_aborted    = r_aborted;
    w_buf_rd     = 1'b0;
    w_buf_addr   = r_buf_addr;
    w_load       = 1'b0;
    w_crc_en     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_tx_en = 1'b0;
        if (tx_if.start && !r_done && tx_if.byte_count != '0) begin
          w_state      = S_FLAG;
          w_tx_en      = 1'b1;
          w_tx_data    = FLAG_BYTE[0];
          w_bit_idx    = 4'd0;
          w_flag_cnt   = 4'd0;
          w_aborted    = 1'b0;
          w_crc        = 16'hFFFF;
          w_buf_rd     = 1'b1;
          w_buf_addr   = tx_if.start_ptr;
          w_rd_ptr     = tx_if.start_ptr + AW'(1);
          w_fetch_left = tx_if.byte_count - AW'(1);
          w_bytes_left = tx_if.byte_count;
        end
      end
      S_FLAG: begin
        if (r_bit_idx[2:0] != 3'd7) begin
          w_bit_idx = r_bit_idx + 4'd1;
          w_tx_data = FLAG_BYTE[w_bit_idx[2:0]];
        end else if (r_flag_cnt == 4'(FLAG_COUNT - 1)) begin
          w_load = 1'b1;
        end else begin
          w_flag_cnt = r_flag_cnt + 4'd1;
          w_bit_idx  = 4'd0;
          w_tx_data  = FLAG_BYTE[0];
        end
      end
      S_DATA, S_FCS: begin
        if (!r_stuff && r_ones == 3'd5) begin
          w_stuff   = 1'b1;
          w_tx_data = 1'b0;
        end else if (r_bit_idx != ((r_state == S_DATA) ? 4'd7 : 4'd15)) begin
          w_bit_idx = r_bit_idx + 4'd1;
          w_tx_data = r_shreg[w_bit_idx];
          w_crc_en  = (r_state == S_DATA);
        end else if (r_state == S_DATA && r_bytes_left != AW'(1)) begin
          w_load       = 1'b1;
          w_bytes_left = r_bytes_left - AW'(1);
        end else if (r_state == S_DATA) begin
          w_state   = S_FCS;
          w_shreg   = ~r_crc;
          w_bit_idx = 4'd0;
          w_tx_data = ~r_crc[0];
        end else begin
          w_state   = S_CLOSE;
          w_bit_idx = 4'd0;
          w_tx_data = FLAG_BYTE[0];
        end
      end
      S_CLOSE: begin
        if (r_bit_idx[2:0] != 3'd7) begin
          w_bit_idx = r_bit_idx + 4'd1;
          w_tx_data = FLAG_BYTE[w_bit_idx[2:0]];
        end else begin
          w_state = S_IDLE;
          w_tx_en = 1'b0;
          w_done  = 1'b1;
        end
      end
      S_ABORT: begin
        if (r_abort_cnt == ACW'(ABORT_ONES)) begin
          w_state   = S_IDLE;
          w_tx_en   = 1'b0;
          w_done    = 1'b1;
          w_aborted = 1'b1;
        end else begin
          w_abort_cnt = r_abort_cnt + ACW'(1);
        end
      end
      default: begin
        w_state = S_IDLE;
        w_tx_en = 1'b0;
      end
    endcase

    // Start the next byte from the prefetch register and fetch the one after it.
    if (w_load) begin
      w_state   = S_DATA;
      w_shreg   = {8'h00, r_next_byte};
      w_bit_idx = 4'd0;
      w_tx_data = r_next_byte[0];
      w_crc_en  = 1'b1;
      if (r_fetch_left != '0) begin
        w_buf_rd     = 1'b1;
        w_buf_addr   = r_rd_ptr;
        w_rd_ptr     = r_rd_ptr + AW'(1);
        w_fetch_left = r_fetch_left - AW'(1);
      end
    end

    if (tx_if.abort && r_state != S_IDLE && r_state != S_ABORT) begin
      w_state     = S_ABORT;
      w_tx_data   = 1'b1;
      w_tx_en     = 1'b1;
      w_abort_cnt = ACW'(1);
      w_stuff     = 1'b0;
      w_crc_en    = 1'b0;
      w_buf_rd    = 1'b0;
      w_buf_addr  = r_buf_addr;
    end

    if (w_crc_en) w_crc = crc_step(r_crc, w_tx_data);

    // Ones run continues across data/FCS but restarts on entry from the flags.
    w_ones_base = (r_state == S_DATA || r_state == S_FCS) ? r_ones : 3'd0;
    w_ones      = ((w_state == S_DATA || w_state == S_FCS) && !w_stuff && w_tx_data)
                  ? w_ones_base + 3'd1 : 3'd0;
  end

  always_ff @(posedge econet_clk or posedge valid_rst) begin
    if (valid_rst) begin
      r_state      <= S_IDLE;
      r_bit_idx    <= '0;
      r_flag_cnt   <= '0;
      r_ones       <= '0;
      r_stuff      <= 1'b0;
      r_shreg      <= '0;
      r_crc        <= '0;
      r_next_byte  <= '0;
      r_rd_ptr     <= '0;
      r_fetch_left <= '0;
      r_bytes_left <= '0;
      r_abort_cnt  <= '0;
      r_tx_data    <= 1'b1;
      r_tx_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_buf_rd     <= 1'b0;
      r_buf_addr   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state      <= w_state;
      r_bit_idx    <= w_bit_idx;
      r_flag_cnt   <= w_flag_cnt;
      r_ones       <= w_ones;
      r_stuff      <= w_stuff;
      r_shreg      <= w_shreg;
      r_crc        <= w_crc;
      r_rd_ptr     <= w_rd_ptr;
      r_fetch_left <= w_fetch_left;
      r_bytes_left <= w_bytes_left;
      r_abort_cnt  <= w_abort_cnt;
      r_tx_data    <= w_tx_data;
      r_tx_en      <= w_tx_en;
      r_busy       <= (w_state != S_IDLE);
      r_done       <= w_done;
      r_aborted    <= w_aborted;
      r_buf_rd     <= w_buf_rd;
      r_buf_addr   <= w_buf_addr;
      if (r_buf_rd) r_next_byte <= tx_if.buf_data;
    end
  end

  assign tx_if.tx_data  = r_tx_data;
  assign tx_if.tx_en    = r_tx_en;
  assign tx_if.busy     = r_busy;
  assign tx_if.done     = r_done;
  assign tx_if.aborted  = r_aborted;
  assign tx_if.buf_rd   = r_buf_rd;
  assign tx_if.buf_addr = r_buf_addr;
endmodule

// File: tb/tb_econet_tx_buffered.sv
// Bench for econet_tx_buffered: table vectors, corner-case sequences and random
// frames compared against a bit-list model of flags, CRC, stuffing and close.
module tb_econet_tx_buffered;
  localparam int FC      = 1;
  localparam int CW      = 9;
  localparam int AB      = 8;
  localparam int MAX_CYC = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  econet_tx_buffered_if #(.ECO_CNTWIDTH(CW)) bus ();

  econet_tx_buffered #(
    .FLAG_COUNT  (FC),
    .ECO_CNTWIDTH(CW),
    .ABORT_ONES  (AB)
  ) dut (
    .econet_clk(clk),
    .valid_rst (rst),
    .tx_if     (bus)
  );

  logic [7:0] mem [512];
  assign bus.buf_data = mem[bus.buf_addr];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit cap_q[$];
  int addr_q[$];
  bit exp_q[$];

  always @(negedge clk) begin
    if (bus.tx_en === 1'b1) cap_q.push_back(bus.tx_data);
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.buf_rd === 1'b1) addr_q.push_back(int'(bus.buf_addr));
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] crc_bit(input logic [15:0] c, input bit b);
    return (c[0] ^ b) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
  endfunction

  // Reference frame as a flat bit list: flags, data+FCS with stuffing, close.
  task automatic build_expected(input int ptr, input int cnt);
    bit          raw[$];
    logic [15:0] crc;
    logic [15:0] fcs;
    logic [7:0]  flag;
    logic [7:0]  b;
    int          ones;
    flag = 8'h7E;
    crc  = 16'hFFFF;
    ones = 0;
    exp_q.delete();
    for (int f = 0; f < FC; f++)
      for (int k = 0; k < 8; k++) exp_q.push_back(flag[k]);
    for (int i = 0; i < cnt; i++) begin
      b = mem[(ptr + i) % 512];
      for (int k = 0; k < 8; k++) begin
        raw.push_back(b[k]);
        crc = crc_bit(crc, b[k]);
      end
    end
    fcs = ~crc;
    for (int k = 0; k < 16; k++) raw.push_back(fcs[k]);
    foreach (raw[i]) begin
      exp_q.push_back(raw[i]);
      ones = raw[i] ? ones + 1 : 0;
      if (ones == 5) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
    for (int k = 0; k < 8; k++) exp_q.push_back(flag[k]);
  endtask

  task automatic run_frame(input string name, input int ptr, input int cnt,
                           input int busy_at, input bit start_on_done);
    int d0;
    int c;
    int en_cnt;
    int mm;
    build_expected(ptr, cnt);
    cap_q.delete();
    addr_q.delete();
    d0 = done_cnt;
    bus.start_ptr  = CW'(ptr);
    bus.byte_count = CW'(cnt);
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    check({name, " first bit {en,data,busy,aborted}"},
          {bus.tx_en, bus.tx_data, bus.busy, bus.aborted}, 4'b1010);
    check({name, " first read addr"}, bus.buf_addr, ptr);
    c = 0;
    while (bus.done !== 1'b1 && c < MAX_CYC) begin
      bus.start = (c == busy_at);
      if (c == busy_at) begin
        bus.start_ptr  = 9'd77;
        bus.byte_count = 9'd2;
      end
      tick();
      c++;
    end
    bus.start = 1'b0;
    check({name, " done seen"}, bus.done, 1);
    check({name, " busy low at done"}, bus.busy, 0);
    if (start_on_done) begin
      bus.start_ptr  = CW'(ptr);
      bus.byte_count = CW'(cnt);
      bus.start      = 1'b1;
    end
    tick();
    bus.start = 1'b0;
    en_cnt = 0;
    repeat (12) begin
      if (bus.tx_en || bus.busy) en_cnt++;
      tick();
    end
    check({name, " idle after done"}, en_cnt, 0);
    check({name, " done pulses"}, done_cnt - d0, 1);
    check({name, " frame length"}, cap_q.size(), exp_q.size());
    mm = -1;
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      if (mm < 0 && cap_q[i] != exp_q[i]) mm = i;
    check({name, " first wrong bit index"}, mm, -1);
    check({name, " read count"}, addr_q.size(), cnt);
    mm = -1;
    foreach (addr_q[i]) if (mm < 0 && addr_q[i] != (ptr + i) % 512) mm = i;
    check({name, " first wrong address index"}, mm, -1);
  endtask

  typedef struct {
    int ptr;
    int cnt;
    int exp_len;  // 0: length taken from the model only
  } vec_t;

  initial begin
    vec_t        vecs[5];
    int          d0;
    int          c;
    int          en_cnt;
    int          ones;
    int          ones_ok;
    bit          ds[$];
    logic [15:0] crc;
    logic [15:0] fcs_got;
    logic [8:0]  ff_got;
    int          rp;
    int          rc;

    vecs[0] = '{0, 9, 104};
    vecs[1] = '{510, 4, 0};
    vecs[2] = '{100, 1, 0};
    vecs[3] = '{200, 3, 0};
    vecs[4] = '{300, 16, 0};

    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) mem[i] = 8'(8'h31 + i);
    mem[510] = 8'h5A;
    mem[511] = 8'hC3;
    mem[100] = 8'hFF;
    for (int i = 200; i < 203; i++) mem[i] = 8'h00;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.start_ptr = '0;
    bus.byte_count = '0;
    repeat (2) tick();
    check("reset tx_data", bus.tx_data, 1);
    check("reset tx_en", bus.tx_en, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    check("reset aborted", bus.aborted, 0);
    check("reset buf_rd", bus.buf_rd, 0);
    check("reset buf_addr", bus.buf_addr, 0);
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      run_frame($sformatf("vec%0d", i), vecs[i].ptr, vecs[i].cnt, -1, 1'b0);
      if (vecs[i].exp_len != 0)
        check($sformatf("vec%0d fixed length", i), cap_q.size(), vecs[i].exp_len);
    end

    // "123456789" with a start request landing mid-frame; then receiver-side checks.
    run_frame("ascii busy start", 0, 9, 40, 1'b0);
    ones = 0;
    ds.delete();
    for (int i = 8 * FC; i < cap_q.size() - 8; i++) begin
      if (ones == 5) ones = 0;
      else begin
        ds.push_back(cap_q[i]);
        ones = cap_q[i] ? ones + 1 : 0;
      end
    end
    check("ascii destuffed bits", ds.size(), 88);
    crc = 16'hFFFF;
    foreach (ds[i]) crc = crc_bit(crc, ds[i]);
    check("ascii residue", crc, 16'hF0B8);
    fcs_got = '0;
    for (int k = 0; k < 16 && 72 + k < ds.size(); k++) fcs_got[k] = ds[72 + k];
    check("ascii fcs", fcs_got, 16'h906E);

    run_frame("ff byte", 100, 1, -1, 1'b0);
    ff_got = '0;
    for (int k = 0; k < 9 && 8 + k < cap_q.size(); k++) ff_got[k] = cap_q[8 + k];
    check("ff stuffed data bits", ff_got, 9'b111011111);

    // Abort mid-DATA, held high through the ABORT sequence.
    cap_q.delete();
    d0 = done_cnt;
    bus.start_ptr  = 9'd0;
    bus.byte_count = 9'd9;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (30) tick();
    check("abort pre tx_en", bus.tx_en, 1);
    bus.abort = 1'b1;
    tick();
    ones_ok = 0;
    repeat (AB) begin
      if (bus.tx_en && bus.tx_data) ones_ok++;
      tick();
    end
    check("abort ones cycles", ones_ok, AB);
    check("abort end {en,data,done,aborted,busy}",
          {bus.tx_en, bus.tx_data, bus.done, bus.aborted, bus.busy}, 5'b01110);
    repeat (4) tick();
    check("abort held no restart", bus.tx_en, 0);
    check("aborted sticky", bus.aborted, 1);
    bus.abort = 1'b0;
    tick();
    check("abort done pulses", done_cnt - d0, 1);
    run_frame("after abort", 3, 5, -1, 1'b0);

    d0 = done_cnt;
    bus.start_ptr  = 9'd5;
    bus.byte_count = 9'd0;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    en_cnt = 0;
    repeat (10) begin
      if (bus.tx_en || bus.busy || bus.buf_rd) en_cnt++;
      tick();
    end
    check("zero count ignored", en_cnt, 0);
    check("zero count no done", done_cnt - d0, 0);

    run_frame("start on done", 0, 9, -1, 1'b1);

    // Reset during the FCS, then a clean frame needing a fresh CRC.
    cap_q.delete();
    d0 = done_cnt;
    bus.start_ptr  = 9'd0;
    bus.byte_count = 9'd9;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    c = 0;
    while (cap_q.size() < 8 * FC + 72 + 4 && c < MAX_CYC) begin
      tick();
      c++;
    end
    check("reached fcs", cap_q.size() >= 8 * FC + 72 + 4, 1);
    #3 rst = 1'b1;
    #1;
    check("mid reset tx_en", bus.tx_en, 0);
    check("mid reset tx_data", bus.tx_data, 1);
    check("mid reset busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    check("mid reset no done", done_cnt - d0, 0);
    run_frame("after reset", 0, 9, -1, 1'b0);

    for (int r = 0; r < 6; r++) begin
      rp = $urandom_range(0, 511);
      rc = $urandom_range(1, 40);
      for (int i = 0; i < rc; i++)
        mem[(rp + i) % 512] = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
      run_frame($sformatf("rand%0d", r), rp, rc, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/econet_tx_buffered.md
Name: econet_tx_buffered

Overview:
Econet/ADLC-style HDLC frame transmitter, the transmit-side counterpart of the buffered Econet receiver. On a start request it reads a frame from an external 512-byte circular transmit buffer and serialises it one bit per econet_clk cycle, LSB first. The serial frame is: opening flag(s), bit-stuffed data, bit-stuffed CRC-16 FCS, closing flag. Status outputs drive the CPU-facing register and interrupt logic. The whole block runs on econet_clk; CPU-side handshake synchronisation is done outside this block.

Parameters:
FLAG_COUNT, 1, number of opening 0x7E flags sent before data (range 1..15).
ECO_CNTWIDTH, 9, width of buffer pointer and byte count (buffer size 2^ECO_CNTWIDTH bytes).
ABORT_ONES, 8, number of consecutive 1 bits sent on abort (must be >= 7).

Ports:
econet_clk  in  1  transmit bit clock; all state changes on its rising edge.
valid_rst  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle request to transmit; sampled only in IDLE.
start_ptr  in  ECO_CNTWIDTH  buffer index of the first frame byte; sampled with start.
byte_count  in  ECO_CNTWIDTH  number of frame bytes; sampled with start.
abort  in  1  level; requests frame abort (e.g. collision detected).
buf_rd  out  1  buffer read strobe.
buf_addr  out  ECO_CNTWIDTH  buffer read address.
buf_data  in  8  buffer read data; valid on the rising edge after the cycle buf_rd is high.
tx_data  out  1  serial line data.
tx_en  out  1  line driver enable.
busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
done  out  1  one-cycle pulse at the end of a frame or abort.
aborted  out  1  high if the last frame ended by abort; cleared on the next accepted start.

Behaviour:
- Reset values: tx_data=1, tx_en=0, busy=0, done=0, aborted=0, buf_rd=0, buf_addr=0. State=IDLE; all counters and the CRC register are cleared.
- All outputs are registered.
- States: IDLE, FLAG, DATA, FCS, CLOSE, ABORT.
- IDLE: tx_en=0, tx_data=1.
  - start with byte_count!=0: latch pointer and count, issue a buf_rd at start_ptr, go to FLAG.
  - start with byte_count==0: ignored; no done pulse.
- Latency: the first flag bit appears on tx_data, with tx_en=1, in the cycle after start is sampled.
- FLAG: sends FLAG_COUNT x 0x7E, LSB first, with no stuffing. The first data byte is prefetched during this state. After the last flag bit, go to DATA.
- DATA: shifts the byte out LSB first. Each emitted data bit (not stuffed zeros) updates the CRC.
  - CRC is CRC-16/X.25: init 0xFFFF, reflected polynomial 0x8408.
  - The next byte is fetched while the current byte shifts.
  - buf_addr = (start_ptr + index) mod 2^ECO_CNTWIDTH; it wraps 511 -> 0.
  - After byte_count bytes, go to FCS.
- FCS: sends ~CRC as 16 bits, low byte first, LSB first. Bits are stuffed but not CRC'd. Then go to CLOSE.
- Bit stuffing (DATA and FCS only):
  - A ones counter counts consecutive 1 bits emitted.
  - After the fifth consecutive 1, the next cycle emits an inserted 0 and the shift/bit index does not advance. The counter then clears.
  - Any emitted 0 clears the counter.
  - The counter clears on entry to DATA; stuffing state never carries across a frame boundary.
  - A stuffed 0 owed after the final FCS bit is sent before the closing flag.
- CLOSE: sends one 0x7E unstuffed. In the next cycle: tx_en=0, tx_data=1, done=1 for one cycle, busy=0, state IDLE.
- Abort:
  - abort high in FLAG/DATA/FCS/CLOSE: go to ABORT on the next edge, truncating the current bit sequence.
  - ABORT drives tx_data=1 with tx_en=1 for ABORT_ONES cycles, then does the IDLE return with done=1 and aborted=1.
  - abort in IDLE has no effect.
  - abort held high during ABORT does not restart the sequence.
- start while busy is ignored. start on the same cycle as the done pulse is also ignored; the block accepts start from the cycle after done.
- valid_rst mid-frame: immediate return to reset values. tx_en drops asynchronously; no done pulse.
- Frame length (cycles with tx_en high) = 8*FLAG_COUNT + 8*byte_count + 16 + stuffed zeros + 8.

Test Plan:
- FLAG_COUNT=1. Buffer at 0 holds ASCII "123456789"; start_ptr=0, byte_count=9 -> tx sequence is 0x7E, the 9 bytes, 0x6E, 0x90, 0x7E, LSB first with stuffing applied. Destuffed frame fed to the receiver gives residue 0xF0B8. done pulses exactly once.
- One byte 0xFF -> data serialises as 1,1,1,1,1,0,1,1,1 (9 cycles); FCS follows with no extra stuffing carried across.
- start_ptr=510, byte_count=4 -> buf_addr sequence 510, 511, 0, 1; bytes are transmitted in that order.
- abort asserted mid-DATA -> the next 8 tx_data bits are 1 with tx_en=1, then tx_en=0, done=1, aborted=1. The next accepted start clears aborted.
- start asserted while busy, and start with byte_count=0 in IDLE -> both ignored: no extra done, and tx_en stays as required.
- valid_rst pulsed mid-FCS -> tx_en=0, tx_data=1, busy=0 immediately, no done pulse. A subsequent start transmits a correct frame with a fresh CRC.
